// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants and FSM state type for the display scan controller
//
// Contents:
//   CODE_DASH, CODE_BLANK : decoder codes for the overflow dash and a blank digit
//   NUM_DIGITS            : number of multiplexed display digits
//   MAX_VALUE             : largest value that can be displayed without overflow
//   state_t               : sequencing FSM states (IDLE, CONVERT, UPDATE)
package display_pkg;

    localparam logic [3:0]  CODE_DASH  = 4'd10;
    localparam logic [3:0]  CODE_BLANK = 4'd11;
    localparam int          NUM_DIGITS = 4;
    localparam logic [13:0] MAX_VALUE  = 14'd9999;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        UPDATE
    } state_t;

endpackage

// File: rtl/display_bcd_conv.sv
// rtl/display_bcd_conv.sv - sequential 14-bit binary to 4-digit BCD double-dabble converter
//
// Ports:
//   clock   in  : system clock, rising edge
//   reset   in  : synchronous active-high reset, abandons any conversion
//   start   in  : load bin_in and clear the BCD accumulator
//   bin_in  in  : 14-bit binary operand
//   bcd     out : 16-bit BCD accumulator, holds the result after the last step
//   finish  out : high during the cycle whose closing edge performs the 14th step
module display_bcd_conv (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [13:0] bin_in,
    output logic [15:0] bcd,
    output logic        finish
);

    logic [13:0] bin;
    logic [3:0]  step_cnt;
    logic        running;
    logic [15:0] adj;

    // Add-3 correction per nibble; a nibble >= 5 can reach at most 12, so no carry out.
    always_comb begin
        adj = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    assign finish = running && (step_cnt == 4'd13);

    always_ff @(posedge clock) begin
        if (reset) begin
            bin      <= '0;
            bcd      <= '0;
            step_cnt <= '0;
            running  <= 1'b0;
        end else if (start) begin
            bin      <= bin_in;
            bcd      <= '0;
            step_cnt <= '0;
            running  <= 1'b1;
        end else if (running) begin
            bcd      <= {adj[14:0], bin[13]};
            bin      <= {bin[12:0], 1'b0};
            step_cnt <= step_cnt + 4'd1;
            if (finish) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - conversion sequencing, digit registers and digit scanner for a 4-digit display
//
// Parameters:
//   SCAN_DIV   : clock cycles each digit stays selected (>= 2)
// Ports:
//   clock      in  : system clock, rising edge
//   reset      in  : synchronous active-high reset
//   value      in  : 14-bit binary value to display
//   load       in  : request conversion of value, honoured only in IDLE
//   busy       out : high while a conversion is in progress
//   done       out : one-cycle pulse when new digits become visible
//   digit_code out : decoder code of the selected digit (0-9, 10 dash, 11 blank)
//   digit_sel  out : active-low one-cold digit select, bit 0 = units
// Build option:
//   DISPLAY_LZB_EN : when defined, leading zero digits are written as blank
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [13:0] value,
    input  logic        load,
    output logic        busy,
    output logic        done,
    output logic [13:0] digit_code,
    output logic [3:0]  digit_sel
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

    state_t        state;
    logic          ovf;
    logic          conv_start;
    logic          conv_finish;
    logic [15:0]   bcd;
    logic [3:0]    digit_reg  [NUM_DIGITS];
    logic [3:0]    next_digit [NUM_DIGITS];
    logic [CW-1:0] scan_cnt;
    logic [1:0]    scan_idx;

    assign conv_start = (state == IDLE) && load;

    display_bcd_conv u_conv (
        .clock  (clock),
        .reset  (reset),
        .start  (conv_start),
        .bin_in (value),
        .bcd    (bcd),
        .finish (conv_finish)
    );

    // Digit values written at UPDATE: dashes on overflow, otherwise the BCD nibbles.
    always_comb begin
`ifdef DISPLAY_LZB_EN
        logic lead_zero;
        lead_zero = !ovf;
`endif
        for (int i = 0; i < NUM_DIGITS; i++) begin
            next_digit[i] = ovf ? CODE_DASH : bcd[4*i +: 4];
        end
`ifdef DISPLAY_LZB_EN
        // Walk down from the most significant digit; the units digit is never blanked.
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            if (lead_zero && (bcd[4*i +: 4] == 4'd0)) begin
                next_digit[i] = CODE_BLANK;
            end else begin
                lead_zero = 1'b0;
            end
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            ovf   <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_reg[i] <= CODE_BLANK;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        state <= CONVERT;
                        busy  <= 1'b1;
                        ovf   <= (value > MAX_VALUE);
                    end
                end
                CONVERT: begin
                    if (conv_finish) begin
                        state <= UPDATE;
                    end
                end
                UPDATE: begin
                    // All digits change on the same edge so no partial result is ever shown.
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        digit_reg[i] <= next_digit[i];
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            scan_cnt <= '0;
            scan_idx <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            scan_idx <= scan_idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    assign digit_sel  = ~(4'b0001 << scan_idx);
    assign digit_code = {10'd0, digit_reg[scan_idx]};

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - self-checking bench for display_scan_ctrl with a behavioural model
module tb_display_scan_ctrl;

    localparam int SD = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        load  = 1'b0;
    logic [13:0] value = '0;
    logic        busy;
    logic        done;
    logic [13:0] digit_code;
    logic [3:0]  digit_sel;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit m_armed = 0;
    bit m_busy;
    bit m_done;
    int m_digits [4];
    int m_scan_cyc;
    int m_phase;
    int m_pend;

    display_scan_ctrl #(.SCAN_DIV(SD)) dut (
        .clock      (clock),
        .reset      (reset),
        .value      (value),
        .load       (load),
        .busy       (busy),
        .done       (done),
        .digit_code (digit_code),
        .digit_sel  (digit_sel)
    );

    always #5 clock = ~clock;

    function automatic void check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", name, got, exp);
        end
    endfunction

    // Decimal digits of v as the display should show them.
    task automatic model_digits(input int v);
        int d [4];
        bit lead;
        if (v > 9999) begin
            for (int i = 0; i < 4; i++) d[i] = 10;
        end else begin
            d[0] = v % 10;
            d[1] = (v / 10) % 10;
            d[2] = (v / 100) % 10;
            d[3] = (v / 1000) % 10;
`ifdef DISPLAY_LZB_EN
            lead = 1;
            for (int i = 3; i > 0; i--) begin
                if (lead && d[i] == 0) d[i] = 11;
                else lead = 0;
            end
`endif
        end
        for (int i = 0; i < 4; i++) m_digits[i] = d[i];
    endtask

    // Model: a conversion takes 15 edges from acceptance to visible digits.
    always @(posedge clock) begin
        if (reset) begin
            m_armed    = 1;
            m_busy     = 0;
            m_done     = 0;
            m_scan_cyc = 0;
            m_phase    = -1;
            for (int i = 0; i < 4; i++) m_digits[i] = 11;
        end else if (m_armed) begin
            m_scan_cyc++;
            m_done = 0;
            if (m_phase < 0) begin
                if (load) begin
                    m_phase = 0;
                    m_pend  = int'(value);
                    m_busy  = 1;
                end
            end else begin
                m_phase++;
                if (m_phase == 15) begin
                    model_digits(m_pend);
                    m_done  = 1;
                    m_busy  = 0;
                    m_phase = -1;
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clock) begin
        int idx;
        if (m_armed) begin
            idx = (m_scan_cyc / SD) % 4;
            check("busy", int'(busy), int'(m_busy));
            check("done", int'(done), int'(m_done));
            check("digit_sel", int'(digit_sel), 15 & ~(1 << idx));
            check("digit_code", int'(digit_code), m_digits[idx]);
        end
    end

    task automatic convert(input int v, output int nbusy);
        bit seen;
        @(negedge clock);
        load  = 1'b1;
        value = 14'(v);
        @(negedge clock);
        load  = 1'b0;
        nbusy = 0;
        seen  = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (busy) nbusy++;
            if (done) seen = 1;
            else @(negedge clock);
        end
        if (!seen) begin
            errors++;
            checks++;
            $display("FAIL timeout_done value %0d got 0 exp 1", v);
        end
    endtask

    // Walk a full scan period and pin each digit slot to a literal code.
    task automatic show_check(input string tag, input int e0, input int e1, input int e2, input int e3);
        int e [4];
        int idx;
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int k = 0; k < 4 * SD; k++) begin
            @(negedge clock);
            idx = -1;
            for (int j = 0; j < 4; j++) begin
                if (digit_sel == (4'hF ^ (4'h1 << j))) idx = j;
            end
            if (idx < 0) begin
                checks++;
                errors++;
                $display("FAIL %s_sel got %0d exp one-cold", tag, digit_sel);
            end else begin
                check(tag, int'(digit_code), e[idx]);
            end
        end
    endtask

    initial begin
        int n;
        int ndone;
        int r;

        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_code", int'(digit_code), 11);
        check("rst_sel", int'(digit_sel), 4'b1110);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        check("rot_sel1", int'(digit_sel), 4'b1101);
        repeat (4) @(negedge clock);
        check("rot_sel2", int'(digit_sel), 4'b1011);
        repeat (4) @(negedge clock);
        check("rot_sel3", int'(digit_sel), 4'b0111);
        repeat (4) @(negedge clock);
        check("rot_sel0", int'(digit_sel), 4'b1110);

        convert(1234, n);
        check("lat_1234", n, 15);
        check("busy_at_done", int'(busy), 0);
        show_check("show_1234", 4, 3, 2, 1);

        convert(7, n);
`ifdef DISPLAY_LZB_EN
        show_check("show_7", 7, 11, 11, 11);
`else
        show_check("show_7", 7, 0, 0, 0);
`endif
        convert(0, n);
`ifdef DISPLAY_LZB_EN
        show_check("show_0", 0, 11, 11, 11);
`else
        show_check("show_0", 0, 0, 0, 0);
`endif

        convert(9999, n);
        check("lat_9999", n, 15);
        show_check("show_9999", 9, 9, 9, 9);
        convert(10000, n);
        check("lat_10000", n, 15);
        show_check("show_10000", 10, 10, 10, 10);
        convert(16383, n);
        check("lat_16383", n, 15);
        show_check("show_16383", 10, 10, 10, 10);

        // Second load at E5 must be ignored.
        @(negedge clock);
        load  = 1'b1;
        value = 14'd1234;
        @(negedge clock);
        load  = 1'b0;
        repeat (4) @(negedge clock);
        load  = 1'b1;
        value = 14'd5678;
        @(negedge clock);
        load  = 1'b0;
        ndone = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clock);
            if (done) ndone++;
        end
        check("busy_load_dones", ndone, 1);
        show_check("show_busy_load", 4, 3, 2, 1);

        // Reset sampled at E8 of a conversion of 4321.
        @(negedge clock);
        load  = 1'b1;
        value = 14'd4321;
        @(negedge clock);
        load  = 1'b0;
        repeat (7) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("midrst_busy", int'(busy), 0);
        check("midrst_code", int'(digit_code), 11);
        reset = 1'b0;
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (done) ndone++;
        end
        check("midrst_no_done", ndone, 0);
        convert(55, n);
        check("lat_55", n, 15);
`ifdef DISPLAY_LZB_EN
        show_check("show_55", 5, 5, 11, 11);
`else
        show_check("show_55", 5, 5, 0, 0);
`endif

        // Random traffic checked cycle by cycle against the model.
        for (int k = 0; k < 1500; k++) begin
            @(negedge clock);
            reset = ($urandom_range(0, 299) == 0);
            load  = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 7);
            case (r)
                0: value = 14'd9999;
                1: value = 14'd10000;
                2: value = 14'd16383;
                3: value = 14'd0;
                default: value = 14'($urandom_range(0, 16383));
            endcase
        end
        reset = 1'b0;
        load  = 1'b0;
        repeat (20) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Sequencing controller for the four-digit seven-segment display. It accepts a 14-bit binary value and converts it to four BCD digits with a sequential double-dabble converter. It then time-multiplexes the digits onto a single shared segment decoder by driving the decoder's 14-bit `number` input and an active-low digit-select bus. It sits between the arithmetic datapath and the existing segment decoder, which stays purely combinational.

## Interface
- `SCAN_DIV`, default 50000: clock cycles each digit stays selected (≥2).
- `clock` in 1: system clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `value` in 14: binary value to display, 0..16383.
- `load` in 1: request conversion of `value`; sampled only in IDLE.
- `busy` out 1: high while a conversion is in progress.
- `done` out 1: one-cycle pulse when the new digits become visible.
- `digit_code` out 14: decoder code for the selected digit (0–9 digit, 10 dash, 11 blank); upper bits always 0.
- `digit_sel` out 4: active-low one-cold select; bit 0 = units digit.

## Operation
- FSM states: IDLE, CONVERT, UPDATE.
  - IDLE + `load` → CONVERT. Captures `value` into a shift register, clears the BCD accumulator, and sets `ovf = (value > 9999)`.
  - CONVERT runs 14 shift steps. Each step first adds 3 to every BCD nibble ≥5, then shifts {bcd, bin} left by 1. After step 14 the FSM goes to UPDATE.
  - UPDATE writes the four display digit registers atomically, pulses `done`, and returns to IDLE.
- Overflow: if `ovf`, all four digit registers are loaded with 10 (dash) and the BCD result is discarded.
- `load` in CONVERT/UPDATE is ignored; no queuing.
- Digit registers hold their contents until the next UPDATE. The display never shows partial results.
- Scanner runs independently of the FSM:
  - Counter 0..SCAN_DIV-1.
  - On wrap, digit index increments 0→1→2→3→0.
  - `digit_sel = ~(1 << index)`.
  - `digit_code = digit_reg[index]`, combinational from registers.
- Width rules: BCD accumulator is 16 bits. Nibble add-3 is 4-bit with no carry out, which is guaranteed by the algorithm. Scan counter width is `$clog2(SCAN_DIV)`.

## Timing
- Reset values:
  - FSM IDLE; `busy` 0; `done` 0.
  - All digit registers 11 (blank), so `digit_code` = 11.
  - Scan counter 0, index 0, `digit_sel` = 4'b1110.
- Latency:
  - `load` sampled at edge E0.
  - `busy` is high from after E0 through E15 (15 cycles).
  - Shift steps occur at E1..E14.
  - UPDATE edge E15 sets the digit registers and `done`=1 for the cycle following E15; `busy` is 0 in that same cycle.
  - A new `load` is accepted at E16 at the earliest.
- Overflow takes the same 15-cycle path (uniform latency).
- `reset` asserted in any state wins over `load`. A conversion in progress is abandoned, and the digits return to blank on the next cycle.
- Scan continues unaffected by conversions. A digit register update appears on `digit_code` the cycle after E15, without waiting for a scan tick.
- Scan index wraps 3→0 with no idle slot.

## Configuration
- `DISPLAY_LZB_EN` defined (leading-zero blanking): in UPDATE, zero digits more significant than the highest non-zero digit are written as 11 (blank). The units digit is always shown, so value 0 displays as "   0". Has no effect on overflow dashes.
- Not defined: all four BCD digits are written unchanged, so 42 displays as "0042".

## Structure
- Package `display_pkg` holds:
  - `CODE_DASH` = 10, `CODE_BLANK` = 11, `NUM_DIGITS` = 4, `MAX_VALUE` = 9999.
  - The FSM state enum (IDLE, CONVERT, UPDATE).
- One sub-module, `display_bcd_conv`, implements the sequential double-dabble shift register and step counter with start/finish strobes. `display_scan_ctrl` holds the FSM, blanking/overflow write logic, digit registers and scanner.
- The existing segment decoder is instantiated outside this block, fed by `digit_code`.

## Test plan
Bench uses `SCAN_DIV` = 4.

- **Reset:** hold `reset` 2 cycles → `busy` 0, `done` 0, `digit_code` 11, `digit_sel` 4'b1110. `digit_sel` rotates 1110→1101→1011→0111→1110 every 4 cycles.
- **Normal conversion:** `load` with `value` = 1234 → `busy` high 15 cycles, `done` pulse the cycle after E15. Scan shows codes 4, 3, 2, 1 at indices 0..3.
- **Leading zeros:** `value` = 7 → with `DISPLAY_LZB_EN` codes 7, 11, 11, 11; without it codes 7, 0, 0, 0. `value` = 0 with the macro → 0, 11, 11, 11.
- **Overflow boundary:**
  - 9999 → 9, 9, 9, 9.
  - 10000 → 10, 10, 10, 10.
  - 16383 → 10, 10, 10, 10.
  - All three take 15-cycle latency.
- **Load while busy:** second `load` with 5678 at E5 → ignored. The result is 1234, and only one `done` pulse occurs.
- **Reset mid-conversion:** `reset` at E8 of converting 4321 → next cycle `busy` 0, all digits 11, no `done`. A subsequent `load` of 55 converts normally.
